// File: rtl/led_pattern_sequencer.sv
// Eight-LED pattern sequencer. A debounced button steps through four animated
// modes, and a prescaler sets the animation rate.
module led_pattern_sequencer #(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    input  logic       PAUSE,
    output logic [7:0] LED,
    output logic [1:0] MODE,
    output logic       TICK
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FILL  = 2'd3
    } mode_t;

    logic          sync1;
    logic          btn_s;
    logic          deb_level;
    logic          deb_prev;
    logic [DW-1:0] deb_cnt;
    logic          adv;

    mode_t         state_q, state_d;
    logic [7:0]    pat_q, pat_d;
    logic          left_q, left_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    // Two-flop synchronizer followed by a counter that must see the new level
    // for DEBOUNCE_CYCLES consecutive cycles before the debounced level flips.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1     <= 1'b0;
            btn_s     <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync1    <= BTN;
            btn_s    <= sync1;
            deb_prev <= deb_level;
            if (btn_s != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= btn_s;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign adv = deb_level & ~deb_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= MODE_COUNT;
            pat_q   <= 8'h00;
            left_q  <= 1'b1;
            pre_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            left_q  <= left_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
        end
    end

    // A mode advance takes priority over a coincident prescaler wrap, so the
    // new mode always starts from its initial pattern with a fresh prescaler.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        left_d  = left_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        if (adv) begin
            unique case (state_q)
                MODE_COUNT: begin state_d = MODE_SCAN;  pat_d = 8'h01; end
                MODE_SCAN:  begin state_d = MODE_BLINK; pat_d = 8'hFF; end
                MODE_BLINK: begin state_d = MODE_FILL;  pat_d = 8'h00; end
                default:    begin state_d = MODE_COUNT; pat_d = 8'h00; end
            endcase
            left_d = 1'b1;
            pre_d  = '0;
        end else if (!PAUSE) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                unique case (state_q)
                    MODE_COUNT: pat_d = pat_q + 8'd1;
                    MODE_SCAN: begin
                        // Bounce off the end LEDs so exactly one stays lit.
                        if (left_q) begin
                            if (pat_q[7]) begin
                                pat_d  = {1'b0, pat_q[7:1]};
                                left_d = 1'b0;
                            end else begin
                                pat_d = {pat_q[6:0], 1'b0};
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d  = {pat_q[6:0], 1'b0};
                                left_d = 1'b1;
                            end else begin
                                pat_d = {1'b0, pat_q[7:1]};
                            end
                        end
                    end
                    MODE_BLINK: pat_d = ~pat_q;
                    default:    pat_d = (pat_q == 8'hFF) ? 8'h00 : {pat_q[6:0], 1'b1};
                endcase
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    assign LED  = pat_q;
    assign MODE = state_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a short prescaler and debounce.
module tb_led_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN = 1'b0;
    logic       PAUSE = 1'b0;
    logic [7:0] LED;
    logic [1:0] MODE;
    logic       TICK;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] scan_exp [28] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                                  8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20,
                                  8'h10, 8'h08, 8'h04, 8'h02};
    logic [7:0] fill_exp [13] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00, 8'h01, 8'h03, 8'h07};

    led_pattern_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .PAUSE(PAUSE),
        .LED(LED), .MODE(MODE), .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic rst, input logic btn, input logic pause);
        RST   = rst;
        BTN   = btn;
        PAUSE = pause;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int idx, input logic [7:0] eLed,
                            input logic [1:0] eMode, input logic eTick);
        checkOutput($sformatf("%s[%0d].LED", tag, idx), LED, eLed);
        checkOutput($sformatf("%s[%0d].MODE", tag, idx), {6'd0, MODE}, {6'd0, eMode});
        checkOutput($sformatf("%s[%0d].TICK", tag, idx), {7'd0, TICK}, {7'd0, eTick});
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        checkAll("reset", 0, 8'h00, 2'd0, 1'b0);

        // Free-running COUNT, including the 256th-tick wrap.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 1100; i++) begin
            @(negedge CLK);
            checkAll("count", i, 8'((i / 4) % 256), 2'd0, (i % 4) == 0);
        end

        // Return to a known state and run up to LED=0x03.
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checkAll("rst2", 0, 8'h00, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge CLK);
        checkAll("pre_press", 0, 8'h03, 2'd0, 1'b1);

        // Press into SCAN: MODE changes on the 11th edge after BTN goes high.
        BTN = 1'b1;
        for (int p = 1; p <= 10; p++) begin
            @(negedge CLK);
            checkAll("press1", p, 8'((12 + p) / 4), 2'd0, ((12 + p) % 4) == 0);
        end
        @(negedge CLK);
        checkAll("press1", 11, 8'h01, 2'd1, 1'b0);

        // Scan sweep, release, then a bouncing burst that must be ignored.
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            checkAll("scan", k, scan_exp[k / 4], 2'd1, (k % 4) == 0);
            if (k == 9 || k >= 90) BTN = 1'b0;
            else if (k >= 60) BTN = (((k - 60) / 3) % 2) == 0;
        end

        // Press into BLINK.
        BTN = 1'b1;
        for (int p = 1; p <= 10; p++) begin
            @(negedge CLK);
            checkAll("press2", p, scan_exp[(100 + p) / 4], 2'd1, ((100 + p) % 4) == 0);
        end
        @(negedge CLK);
        checkAll("press2", 11, 8'hFF, 2'd2, 1'b0);
        for (int b = 1; b <= 24; b++) begin
            @(negedge CLK);
            checkAll("blink", b, (((b / 4) % 2) == 0) ? 8'hFF : 8'h00, 2'd2, (b % 4) == 0);
            if (b == 1) BTN = 1'b0;
        end

        // Press into FILL.
        BTN = 1'b1;
        for (int p = 1; p <= 10; p++) begin
            @(negedge CLK);
            checkAll("press3", p, ((((24 + p) / 4) % 2) == 0) ? 8'hFF : 8'h00, 2'd2, ((24 + p) % 4) == 0);
        end
        @(negedge CLK);
        checkAll("press3", 11, 8'h00, 2'd3, 1'b0);
        for (int f = 1; f <= 41; f++) begin
            @(negedge CLK);
            checkAll("fill", f, fill_exp[f / 4], 2'd3, (f % 4) == 0);
            if (f == 1) BTN = 1'b0;
        end

        // Press into COUNT timed so adv lands on a prescaler wrap.
        BTN = 1'b1;
        for (int p = 1; p <= 10; p++) begin
            @(negedge CLK);
            checkAll("press4", p, fill_exp[(41 + p) / 4], 2'd3, ((41 + p) % 4) == 0);
        end
        @(negedge CLK);
        checkAll("collide", 11, 8'h00, 2'd0, 1'b0);
        for (int c = 1; c <= 22; c++) begin
            @(negedge CLK);
            checkAll("after_collide", c, 8'(c / 4), 2'd0, (c % 4) == 0);
            if (c == 1) BTN = 1'b0;
        end

        // Pause at LED=0x05 with two prescaler counts already spent.
        PAUSE = 1'b1;
        for (int q = 1; q <= 50; q++) begin
            @(negedge CLK);
            checkAll("pause", q, 8'h05, 2'd0, 1'b0);
        end
        PAUSE = 1'b0;
        @(negedge CLK);
        checkAll("unpause", 1, 8'h05, 2'd0, 1'b0);
        @(negedge CLK);
        checkAll("unpause", 2, 8'h06, 2'd0, 1'b1);

        // A press while paused still changes mode.
        PAUSE = 1'b1;
        BTN   = 1'b1;
        for (int p = 1; p <= 20; p++) begin
            @(negedge CLK);
            if (p <= 10) checkAll("pause_press", p, 8'h06, 2'd0, 1'b0);
            else         checkAll("pause_press", p, 8'h01, 2'd1, 1'b0);
            if (p == 12) BTN = 1'b0;
        end
        PAUSE = 1'b0;
        for (int u = 1; u <= 6; u++) begin
            @(negedge CLK);
            checkAll("resume", u, (u >= 4) ? 8'h02 : 8'h01, 2'd1, u == 4);
        end

        // Reset asserted between clock edges takes effect immediately.
        #2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        #1;
        checkAll("async_rst", 0, 8'h00, 2'd0, 1'b0);
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 8; r++) begin
            @(negedge CLK);
            checkAll("post_rst", r, 8'(r / 4), 2'd0, (r % 4) == 0);
        end

        // Button held through reset release is accepted as one press.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge CLK);
        checkAll("held_rst", 0, 8'h00, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 10; r++) begin
            @(negedge CLK);
            checkAll("held", r, 8'(r / 4), 2'd0, (r % 4) == 0);
        end
        @(negedge CLK);
        checkAll("held", 11, 8'h01, 2'd1, 1'b0);
        BTN = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            checkAll("held_scan", k, scan_exp[k / 4], 2'd1, (k % 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
